// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fifo_pkg
// Purpose : Shared FIFO sizing defaults for the write-side and read-side
//           pointer blocks of the asynchronous FIFO.
// Contents: ADDR_WIDTH_DEF, DEPTH_DEF, AF_THRESH_DEF
// Revision: 1.0 - initial release
// ============================================================================
package fifo_pkg;

  localparam int ADDR_WIDTH_DEF = 3;
  localparam int DEPTH_DEF      = 2 ** ADDR_WIDTH_DEF;
  localparam int AF_THRESH_DEF  = 6;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/gray2bin.sv
`default_nettype none
// ============================================================================
// Module  : gray2bin
// Purpose : Combinational Gray-to-binary converter, shared by both sides of
//           the asynchronous FIFO.
// Ports   : gray - Gray-coded input  [WIDTH-1:0]
//           bin  - binary output     [WIDTH-1:0]
// Revision: 1.0 - initial release
// ============================================================================
module gray2bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above its position.
  always_comb begin
    bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule : gray2bin
`default_nettype wire

// File: rtl/w_point_full.sv
`default_nettype none
// ============================================================================
// Module  : w_point_full
// Purpose : Write-domain pointer, full, level and overflow logic of an
//           asynchronous FIFO. Runs entirely on w_clk.
// Macro   : W_ALMOST_FULL_EN - builds the registered almost-full compare;
//           when undefined w_almost_full is tied low and AF_THRESH is unused.
// Ports   : w_clk, w_rstn (async, active-low)
//           w_en          - write request
//           wq2_rptr      - synchronized Gray read pointer
//           w_ovf_clr     - clears the sticky overflow flag
//           w_point       - registered Gray write pointer
//           w_addr        - memory write address
//           w_full        - registered full flag
//           w_level       - registered (pessimistic) fill level
//           w_almost_full - registered almost-full flag
//           w_overflow    - sticky write-while-full flag
// Revision: 1.0 - initial release
// ============================================================================
module w_point_full
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int AF_THRESH  = AF_THRESH_DEF
) (
  input  logic                  w_clk,
  input  logic                  w_rstn,
  input  logic                  w_en,
  input  logic [ADDR_WIDTH:0]   wq2_rptr,
  input  logic                  w_ovf_clr,
  output logic [ADDR_WIDTH:0]   w_point,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic                  w_full,
  output logic [ADDR_WIDTH:0]   w_level,
  output logic                  w_almost_full,
  output logic                  w_overflow
);

  logic [ADDR_WIDTH:0] bin_q,   bin_d;
  logic [ADDR_WIDTH:0] gray_q,  gray_d;
  logic [ADDR_WIDTH:0] level_q, level_d;
  logic                full_q,  full_d;
  logic                ovf_q,   ovf_d;
  logic [ADDR_WIDTH:0] rbin;
  logic                w_inc;

  gray2bin #(
    .WIDTH (ADDR_WIDTH + 1)
  ) u_rptr_g2b (
    .gray (wq2_rptr),
    .bin  (rbin)
  );

  always_comb begin
    w_inc   = w_en & ~full_q;
    bin_d   = bin_q + {{ADDR_WIDTH{1'b0}}, w_inc};
    gray_d  = (bin_d >> 1) ^ bin_d;
    // Full when the next write pointer has lapped the read pointer once:
    // in Gray code that is the read pointer with its two MSBs inverted.
    full_d  = (gray_d == {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1],
                          wq2_rptr[ADDR_WIDTH-2:0]});
    level_d = bin_d - rbin;
    // A new overflow event takes priority over a simultaneous clear.
    ovf_d   = (w_en & full_q) | (ovf_q & ~w_ovf_clr);
  end

  always_ff @(posedge w_clk or negedge w_rstn) begin
    if (!w_rstn) begin
      bin_q   <= '0;
      gray_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      level_q <= level_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef W_ALMOST_FULL_EN
  localparam logic [ADDR_WIDTH:0] AF_LVL = (ADDR_WIDTH + 1)'(AF_THRESH);

  logic af_q, af_d;

  always_comb begin
    af_d = (level_d >= AF_LVL);
  end

  always_ff @(posedge w_clk or negedge w_rstn) begin
    if (!w_rstn) begin
      af_q <= 1'b0;
    end else begin
      af_q <= af_d;
    end
  end

  assign w_almost_full = af_q;
`else
  logic unused_af_thresh;
  assign unused_af_thresh = &{1'b0, AF_THRESH[0]};
  assign w_almost_full    = 1'b0;
`endif

  // Gray pointer leaves straight from its flop so the read-domain
  // synchronizer never sees combinational glitches.
  assign w_point    = gray_q;
  assign w_addr     = bin_q[ADDR_WIDTH-1:0];
  assign w_full     = full_q;
  assign w_level    = level_q;
  assign w_overflow = ovf_q;

endmodule : w_point_full
`default_nettype wire

// File: tb/tb_w_point_full.sv
`default_nettype none
// ============================================================================
// Module  : tb_w_point_full
// Purpose : Self-checking bench for w_point_full with a counter-based
//           reference model of the write side of the FIFO.
// Revision: 1.0 - initial release
// ============================================================================
module tb_w_point_full;

`ifdef W_ALMOST_FULL_EN
  localparam bit AFEN = 1'b1;
`else
  localparam bit AFEN = 1'b0;
`endif
  localparam int DEPTH = 8;
  localparam int PMOD  = 16;

  logic       w_clk = 1'b0;
  logic       w_rstn = 1'b0;
  logic       w_en = 1'b0;
  logic [3:0] wq2_rptr = '0;
  logic       w_ovf_clr = 1'b0;
  logic [3:0] w_point;
  logic [2:0] w_addr;
  logic       w_full;
  logic [3:0] w_level;
  logic       w_almost_full;
  logic       w_overflow;

  w_point_full dut (
    .w_clk         (w_clk),
    .w_rstn        (w_rstn),
    .w_en          (w_en),
    .wq2_rptr      (wq2_rptr),
    .w_ovf_clr     (w_ovf_clr),
    .w_point       (w_point),
    .w_addr        (w_addr),
    .w_full        (w_full),
    .w_level       (w_level),
    .w_almost_full (w_almost_full),
    .w_overflow    (w_overflow)
  );

  always #5 w_clk = ~w_clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: write count, read count, derived flags.
  int m_w, m_r, m_level;
  bit m_full, m_ovf, m_af;

  wire [13:0] obs = {w_point, w_addr, w_full, w_level, w_almost_full, w_overflow};

  function automatic logic [3:0] to_gray(input int v);
    logic [3:0] b;
    b = v[3:0];
    return b ^ (b >> 1);
  endfunction

  function automatic logic [13:0] exp_vec();
    logic [3:0] w4, l4;
    w4 = m_w[3:0];
    l4 = m_level[3:0];
    return {to_gray(m_w), w4[2:0], m_full, l4, m_af, m_ovf};
  endfunction

  task automatic model_reset();
    m_w = 0; m_level = 0; m_full = 0; m_ovf = 0; m_af = 0;
  endtask

  // Drive one cycle of inputs; rb is the binary read count the synchronizer
  // presents. Returns #1 after the edge with the model updated.
  task automatic step(input bit en, input bit clr, input int rb);
    bit inc;
    w_en      = en;
    w_ovf_clr = clr;
    m_r       = rb & (PMOD - 1);
    wq2_rptr  = to_gray(m_r);
    @(posedge w_clk);
    inc     = en && !m_full;
    m_ovf   = (en && m_full) || (m_ovf && !clr);
    m_w     = (m_w + int'(inc)) % PMOD;
    m_level = (m_w - m_r + PMOD) % PMOD;
    m_full  = (m_level == DEPTH);
    m_af    = AFEN && (m_level >= 6);
    #1;
  endtask

  task automatic hold_reset();
    w_rstn = 1'b0;
    w_en = 1'b0; w_ovf_clr = 1'b0; wq2_rptr = '0; m_r = 0;
    #2;
    model_reset();
  endtask

  task automatic release_reset();
    @(posedge w_clk);
    #1;
    w_rstn = 1'b1;
  endtask

  task automatic test_reset();
    hold_reset();
    n_cmp++;
    if (obs !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_state: got %h want %h", obs, 14'h0);
    end
    release_reset();
  endtask

  task automatic test_fill();
    logic [3:0] gseq [8] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (w_addr !== 3'(i)) begin
        n_fail++;
        $display("FAIL fill_addr[%0d]: got %0d want %0d", i, w_addr, i);
      end
      step(1'b1, 1'b0, 0);
      n_cmp++;
      if (w_point !== gseq[i]) begin
        n_fail++;
        $display("FAIL fill_point[%0d]: got %h want %h", i, w_point, gseq[i]);
      end
      n_cmp++;
      if (w_almost_full !== (AFEN && (i + 1 >= 6))) begin
        n_fail++;
        $display("FAIL fill_af[%0d]: got %b want %b", i, w_almost_full, AFEN && (i + 1 >= 6));
      end
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL fill_vec[%0d]: got %h want %h", i, obs, exp_vec());
      end
    end
    n_cmp++;
    if ({w_full, w_level} !== {1'b1, 4'd8}) begin
      n_fail++;
      $display("FAIL fill_full: got full=%b level=%0d want full=1 level=8", w_full, w_level);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 0);
      n_cmp++;
      if ({w_point, w_overflow} !== {4'hC, 1'b1}) begin
        n_fail++;
        $display("FAIL ovf_set[%0d]: got point=%h ovf=%b want point=C ovf=1", i, w_point, w_overflow);
      end
    end
    step(1'b0, 1'b1, 0);
    n_cmp++;
    if (w_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got %b want 0", w_overflow);
    end
    step(1'b1, 1'b1, 0);
    n_cmp++;
    if (w_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set_wins: got %b want 1", w_overflow);
    end
    n_cmp++;
    if (obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL ovf_vec: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_read_move();
    step(1'b0, 1'b1, 2);
    n_cmp++;
    if ({w_full, w_level} !== {1'b0, 4'd6}) begin
      n_fail++;
      $display("FAIL read_move: got full=%b level=%0d want full=0 level=6", w_full, w_level);
    end
    n_cmp++;
    if (obs !== exp_vec()) begin
      n_fail++;
      $display("FAIL read_move_vec: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_wrap();
    bit         wrapped = 0;
    logic [3:0] prev;
    hold_reset();
    release_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 0);
    for (int i = 0; i < 20; i++) begin
      prev = w_point;
      step(1'b1, 1'b0, m_w - 3);
      if (prev == 4'h8 && w_point == 4'h0) wrapped = 1;
      n_cmp++;
      if ({w_full, w_level} !== {1'b0, 4'd4}) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got full=%b level=%0d want full=0 level=4", i, w_full, w_level);
      end
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL wrap_vec[%0d]: got %h want %h", i, obs, exp_vec());
      end
    end
    n_cmp++;
    if (wrapped !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_seen: got %b want 1", wrapped);
    end
  endtask

  task automatic test_random();
    hold_reset();
    release_reset();
    for (int i = 0; i < 400; i++) begin
      int adv;
      adv = $urandom_range(0, (m_w - m_r + PMOD) % PMOD);
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0), m_r + adv);
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h want %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    hold_reset();
    release_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 0);
    n_cmp++;
    if (w_level !== 4'd5) begin
      n_fail++;
      $display("FAIL mid_level: got %0d want 5", w_level);
    end
    #2;
    hold_reset();
    n_cmp++;
    if (obs !== 14'h0) begin
      n_fail++;
      $display("FAIL mid_reset: got %h want %h", obs, 14'h0);
    end
    release_reset();
    n_cmp++;
    if (w_addr !== 3'd0) begin
      n_fail++;
      $display("FAIL mid_resume0: got %0d want 0", w_addr);
    end
    step(1'b1, 1'b0, 0);
    n_cmp++;
    if (obs !== exp_vec() || w_addr !== 3'd1) begin
      n_fail++;
      $display("FAIL mid_resume1: got %h want %h", obs, exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_read_move();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_w_point_full
`default_nettype wire
